mu0_word_tx: RTL
================

# mu0_word_tx

Serial transmitter for the MU0 16-bit datapath. Takes a 16-bit word on a parallel load strobe, as a register would, and shifts it out on a single wire as a framed asynchronous serial character. It is the read-out end of a 16-bit register: it consumes the D/En load interface and converts the stored word to a bit stream for off-chip observation.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Legal range 2..255.
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset. Low forces reset state immediately; release is synchronous to Clk.
- En  input  1  load strobe; sampled on the rising edge of Clk.
- D  input  16  word to transmit; captured when a load is accepted.
- TxD  output  1  serial line; idle high.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- Reset values: TxD=1, Busy=0, Done=0, state IDLE, shift register 16'h0000, bit counter 0, baud counter 0.
- States:
  - IDLE: TxD=1, Busy=0. If En=1 on a rising edge, capture D into the shift register and go to START.
  - START: TxD=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 16 bits, LSB first. Each bit is held for CLKS_PER_BIT cycles. After each bit, shift right by one and increment the bit counter. After bit 15, go to PARITY if parity is compiled in, otherwise go to STOP.
  - PARITY: optional, see Configuration.
  - STOP: TxD=1 for CLKS_PER_BIT cycles. Done=1 during the final cycle. Then go to IDLE.
- Busy=1 in every state except IDLE.
- Load acceptance:
  - En is ignored while Busy=1, including during the Done cycle. The word is not queued.
  - D changes after capture have no effect on the frame in progress.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its wrap advances the bit or state. It is cleared on entry to START.
- Bit counter is 5 bits wide and counts 0..15. It is cleared on entry to DATA.
- Reset asserted mid-frame:
  - TxD returns to 1 and Busy/Done to 0 immediately, without waiting for a clock.
  - The frame is abandoned. There is no resume after release.

## Timing
- Load latency: En sampled high in IDLE at edge N → TxD=0 and Busy=1 after edge N.
- Frame length without parity: 18×CLKS_PER_BIT cycles (72 at default). With parity: 19×CLKS_PER_BIT (76 at default).
- Done is high for exactly one cycle, ending at the edge where the state returns to IDLE. Busy falls at that same edge.
- Back-to-back frames:
  - The earliest new load is the first IDLE cycle after Done.
  - The gap between the stop bit and the next start bit is at least one clock cycle of TxD=1.
- All outputs are registered. There is no combinational path from En or D to TxD, Busy or Done.

## Configuration
- Macro: MU0_WORD_TX_PARITY_EN.
- Defined: the PARITY state follows DATA. TxD holds the even-parity bit (XOR of the 16 captured bits) for CLKS_PER_BIT cycles. A parity register holds this bit and is computed at capture.
- Undefined: there is no PARITY state, DATA goes directly to STOP, and the parity logic is not synthesised.

## Test plan
- Reset sequence: Reset=0 with En=1 and D=16'hAAAA for 2 cycles → TxD=1, Busy=0, Done=0 throughout, and no frame starts while Reset=0.
- Basic frame (CLKS_PER_BIT=4, no parity): En pulse with D=16'hBBBB → TxD=0 for 4 cycles, then bits 1,1,0,1,1,1,0,1,1,1,0,1,1,1,0,1 at 4 cycles each, then 1 for 4 cycles. Done pulses at cycle 72 and Busy is high for 72 cycles.
- Load while busy: a second En with D=16'h1234 at cycle 20 of a frame → the frame is unaltered and no second frame starts after Done.
- Asynchronous reset: Reset=0 asserted between clock edges during DATA → TxD=1 and Busy=0 before the next edge. After release, the line stays idle until a new En.
- Parity build (MU0_WORD_TX_PARITY_EN defined): D=16'h0001 → parity bit 1, frame 76 cycles. D=16'h0003 → parity bit 0.
- Back-to-back: En held high continuously → frames repeat with exactly one idle cycle of TxD=1 between the stop bit and the next start bit. Each frame carries the D value present at its capture edge.

Source files
------------

// File: rtl/mu0_word_tx.sv
// Framed asynchronous serial transmitter for a 16-bit word: start bit, 16 data bits LSB first,
// optional even parity (MU0_WORD_TX_PARITY_EN), stop bit. All outputs registered.
module mu0_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [15:0] i_d,
  output logic        o_txd,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [7:0] LastCnt    = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] PreLastCnt = 8'(CLKS_PER_BIT - 2);

  state_e      r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;
  logic [7:0]  r_baud_cnt;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;
`ifdef MU0_WORD_TX_PARITY_EN
  logic        r_parity;
`endif

  logic w_baud_last;
  assign w_baud_last = (r_baud_cnt == LastCnt);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_shift    <= 16'h0000;
      r_bit_cnt  <= 5'd0;
      r_baud_cnt <= 8'd0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef MU0_WORD_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state != StIdle) begin
        r_baud_cnt <= w_baud_last ? 8'd0 : r_baud_cnt + 8'd1;
      end
      case (r_state)
        StIdle: begin
          if (i_en) begin
            r_state    <= StStart;
            r_shift    <= i_d;
            r_baud_cnt <= 8'd0;
            r_txd      <= 1'b0;
            r_busy     <= 1'b1;
`ifdef MU0_WORD_TX_PARITY_EN
            r_parity   <= ^i_d;
`endif
          end
        end
        StStart: begin
          if (w_baud_last) begin
            r_state   <= StData;
            r_bit_cnt <= 5'd0;
            r_txd     <= r_shift[0];
          end
        end
        StData: begin
          if (w_baud_last) begin
            r_shift <= {1'b0, r_shift[15:1]};
            if (r_bit_cnt == 5'd15) begin
`ifdef MU0_WORD_TX_PARITY_EN
              r_state <= StParity;
              r_txd   <= r_parity;
`else
              r_state <= StStop;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_txd     <= r_shift[1];
            end
          end
        end
`ifdef MU0_WORD_TX_PARITY_EN
        StParity: begin
          if (w_baud_last) begin
            r_state <= StStop;
            r_txd   <= 1'b1;
          end
        end
`endif
        StStop: begin
          // Raise Done one edge early so the registered pulse lands on the final stop cycle.
          if (r_baud_cnt == PreLastCnt) r_done <= 1'b1;
          if (w_baud_last) begin
            r_state <= StIdle;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_txd  = r_txd;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule
